id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Parametrised decode/ID-EX pipeline stage for the next-generation core.
- Holds an XLEN×NREGS register file with write-first bypass and hardwired x0.
- Registers operands, immediate, PC pair, instruction and an opaque decoded control bundle into EX.
- Adds internal load-use hazard detection, a valid bit, and flush requests that survive a memory stall; the previous decode stage lacked all three.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register count (power of two); RW = log2(NREGS).
- CTRL_W, 40, width of the decoded control bundle from the instruction decoder.
- NOP_INSN, 32'h00000013, instruction word inserted on bubbles.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- stall_mem  in  1  freeze ID/EX register.
- flush  in  1  squash the instruction currently in ID.
- instr_valid  in  1  ID holds a real instruction.
- instr  in  32  instruction in ID.
- curr_pc  in  XLEN  PC of instr.
- next_pc  in  XLEN  PC+4 of instr.
- ctrl_in  in  CTRL_W  decoded controls for instr.
- imm_in  in  XLEN  sign-extended immediate for instr.
- is_load  in  1  instr is a load.
- wb_en  in  1  writeback enable.
- wb_reg  in  RW  writeback register.
- wb_data  in  XLEN  writeback data.
- hazard_out  out  1  load-use stall request to fetch (combinational).
- branch_alert  out  1  branch/jump in ID or EX (combinational).
- valid_ex  out  1  EX slot holds a real instruction.
- rs1_data_ex  out  XLEN  rs1 operand.
- rs2_data_ex  out  XLEN  rs2 operand.
- imm_ex  out  XLEN  immediate.
- pc_ex  out  XLEN  curr_pc.
- next_pc_ex  out  XLEN  next_pc.
- instr_ex  out  32  instruction.
- ctrl_ex  out  CTRL_W  controls.
- rd_ex  out  RW  destination register.
- rs1_ex  out  RW  source register 1, for forwarding.
- rs2_ex  out  RW  source register 2, for forwarding.
- is_load_ex  out  1  load flag.

Behaviour:
- Field decode: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], all truncated/zero-extended to RW.
- Register file write:
  - Synchronous on wb_en; writes to reg 0 are ignored.
  - Writes occur even while stall_mem=1.
- Register file read:
  - Combinational; reg 0 always reads 0.
  - Write-first bypass: if wb_en and wb_reg==rsN≠0, the read returns wb_data in the same cycle.
- hazard_out = instr_valid & valid_ex & is_load_ex & rd_ex≠0 & (rd_ex==rs1 | rd_ex==rs2) & ~stall_mem.
- kill = flush | flush_pend | hazard_out.
- ID/EX register update, priority rst > stall_mem > kill > load:
  - rst: every output register goes to 0, except instr_ex=NOP_INSN. Register file and flush_pend clear to 0.
  - stall_mem=1: all ID/EX outputs hold. If flush=1, set flush_pend=1.
  - kill (not stalled): bubble. valid_ex=0, ctrl_ex/rd_ex/rs*_ex/is_load_ex/data/imm/pc fields = 0, instr_ex=NOP_INSN. Clear flush_pend.
  - Otherwise: capture all ID fields; valid_ex=instr_valid.
  - If instr_valid=0 when loading, control fields are zeroed exactly as for a bubble.
- Latency: one cycle from ID inputs to *_ex outputs.
- A hazard bubble lasts exactly one cycle; fetch holds the ID instruction via hazard_out. On the next cycle the load has left EX, so hazard_out falls.
- Simultaneous flush and hazard: treated as flush; hazard_out is still asserted combinationally that cycle.
- branch_alert = (instr_valid & opcode∈{1100011,1100111,1101111}) | (valid_ex & instr_ex opcode∈same set).
- Reset mid-stall drops any pending flush; no state survives reset.

Test Plan:
- Reset, then write x5=0xDEADBEEF via wb. Issue `add x1,x5,x0`, instr_valid=1, ctrl_in=0x1234 → next cycle rs1_data_ex=0xDEADBEEF, ctrl_ex=0x1234, valid_ex=1, rd_ex=1.
- Same-cycle writeback: wb_en=1, wb_reg=7, wb_data=0x55 while ID reads rs2=7 → rs2_data_ex=0x55. A write to x0 of 0xFF → x0 still reads 0.
- Load-use: `lw x3,0(x2)` into EX, then `add x4,x3,x1` in ID → hazard_out=1 for one cycle, EX gets bubble (instr_ex=0x00000013, valid_ex=0). Next cycle hazard_out=0 and the add enters EX.
- Flush during stall: stall_mem=1 for 3 cycles with flush pulsed in cycle 1 → outputs frozen throughout. First unstalled edge inserts a bubble, and flush_pend clears.
- Branch alert: `beq` in ID → branch_alert=1; next cycle, with a non-branch in ID, alert stays 1 (branch in EX). After a bubble it drops to 0.
- Async reset asserted mid-cycle with valid_ex=1 → valid_ex=0 and instr_ex=NOP_INSN before the next clock edge; previously written registers read 0.

Source files
------------

// File: rtl/id_ex_if.sv
// Signal bundle between decode, the ID/EX register and writeback.
// The slave modport belongs to id_ex_stage. The master modport belongs to the surrounding pipeline.
interface id_ex_if #(
    parameter int XLEN   = 32,
    parameter int RW     = 5,
    parameter int CTRL_W = 40
);
    logic              stall_mem;
    logic              flush;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [XLEN-1:0]   curr_pc;
    logic [XLEN-1:0]   next_pc;
    logic [CTRL_W-1:0] ctrl_in;
    logic [XLEN-1:0]   imm_in;
    logic              is_load;
    logic              wb_en;
    logic [RW-1:0]     wb_reg;
    logic [XLEN-1:0]   wb_data;

    logic              hazard_out;
    logic              branch_alert;
    logic              valid_ex;
    logic [XLEN-1:0]   rs1_data_ex;
    logic [XLEN-1:0]   rs2_data_ex;
    logic [XLEN-1:0]   imm_ex;
    logic [XLEN-1:0]   pc_ex;
    logic [XLEN-1:0]   next_pc_ex;
    logic [31:0]       instr_ex;
    logic [CTRL_W-1:0] ctrl_ex;
    logic [RW-1:0]     rd_ex;
    logic [RW-1:0]     rs1_ex;
    logic [RW-1:0]     rs2_ex;
    logic              is_load_ex;

    modport master (
        output stall_mem, flush, instr_valid, instr,
        output curr_pc, next_pc, ctrl_in, imm_in, is_load,
        output wb_en, wb_reg, wb_data,
        input  hazard_out, branch_alert, valid_ex,
        input  rs1_data_ex, rs2_data_ex, imm_ex,
        input  pc_ex, next_pc_ex, instr_ex, ctrl_ex,
        input  rd_ex, rs1_ex, rs2_ex, is_load_ex
    );

    modport slave (
        input  stall_mem, flush, instr_valid, instr,
        input  curr_pc, next_pc, ctrl_in, imm_in, is_load,
        input  wb_en, wb_reg, wb_data,
        output hazard_out, branch_alert, valid_ex,
        output rs1_data_ex, rs2_data_ex, imm_ex,
        output pc_ex, next_pc_ex, instr_ex, ctrl_ex,
        output rd_ex, rs1_ex, rs2_ex, is_load_ex
    );
endinterface

// File: rtl/id_ex_stage.sv
// Decode-side register file plus the ID/EX pipeline register.
// Also detects load-use hazards and keeps a flush request alive across memory stalls.
module id_ex_stage #(
    parameter int          XLEN     = 32,
    parameter int          NREGS    = 32,
    parameter int          CTRL_W   = 40,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input logic   clk,
    input logic   rst,
    id_ex_if.slave bus
);
    localparam int RW = $clog2(NREGS);

    logic [XLEN-1:0] rf [NREGS];
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            flush_pend;
    logic            hazard;
    logic            kill;

    function automatic logic is_branch(input logic [6:0] op);
        return (op == 7'b1100011) || (op == 7'b1100111) ||
               (op == 7'b1101111);
    endfunction

    assign rs1 = RW'(bus.instr[19:15]);
    assign rs2 = RW'(bus.instr[24:20]);
    assign rd  = RW'(bus.instr[11:7]);

    // Same-cycle writeback is forwarded so that ID never reads a stale value.
    always_comb begin
        rs1_val = rf[rs1];
        rs2_val = rf[rs2];
        if (rs1 == '0)
            rs1_val = '0;
        else if (bus.wb_en && bus.wb_reg == rs1)
            rs1_val = bus.wb_data;
        if (rs2 == '0)
            rs2_val = '0;
        else if (bus.wb_en && bus.wb_reg == rs2)
            rs2_val = bus.wb_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (bus.wb_en && bus.wb_reg != '0) begin
            rf[bus.wb_reg] <= bus.wb_data;
        end
    end

    assign hazard = bus.instr_valid & bus.valid_ex & bus.is_load_ex &
                    (bus.rd_ex != '0) &
                    ((bus.rd_ex == rs1) | (bus.rd_ex == rs2)) &
                    ~bus.stall_mem;

    assign kill = bus.flush | flush_pend | hazard;

    assign bus.hazard_out   = hazard;
    assign bus.branch_alert =
        (bus.instr_valid & is_branch(bus.instr[6:0])) |
        (bus.valid_ex & is_branch(bus.instr_ex[6:0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pend      <= 1'b0;
            bus.valid_ex    <= 1'b0;
            bus.rs1_data_ex <= '0;
            bus.rs2_data_ex <= '0;
            bus.imm_ex      <= '0;
            bus.pc_ex       <= '0;
            bus.next_pc_ex  <= '0;
            bus.instr_ex    <= NOP_INSN;
            bus.ctrl_ex     <= '0;
            bus.rd_ex       <= '0;
            bus.rs1_ex      <= '0;
            bus.rs2_ex      <= '0;
            bus.is_load_ex  <= 1'b0;
        end else if (bus.stall_mem) begin
            if (bus.flush)
                flush_pend <= 1'b1;
        end else begin
            flush_pend <= 1'b0;
            // An empty ID slot is treated as a bubble, the same as a killed instruction.
            if (kill || !bus.instr_valid) begin
                bus.valid_ex    <= 1'b0;
                bus.rs1_data_ex <= '0;
                bus.rs2_data_ex <= '0;
                bus.imm_ex      <= '0;
                bus.pc_ex       <= '0;
                bus.next_pc_ex  <= '0;
                bus.instr_ex    <= NOP_INSN;
                bus.ctrl_ex     <= '0;
                bus.rd_ex       <= '0;
                bus.rs1_ex      <= '0;
                bus.rs2_ex      <= '0;
                bus.is_load_ex  <= 1'b0;
            end else begin
                bus.valid_ex    <= 1'b1;
                bus.rs1_data_ex <= rs1_val;
                bus.rs2_data_ex <= rs2_val;
                bus.imm_ex      <= bus.imm_in;
                bus.pc_ex       <= bus.curr_pc;
                bus.next_pc_ex  <= bus.next_pc;
                bus.instr_ex    <= bus.instr;
                bus.ctrl_ex     <= bus.ctrl_in;
                bus.rd_ex       <= rd;
                bus.rs1_ex      <= rs1;
                bus.rs2_ex      <= rs2;
                bus.is_load_ex  <= bus.is_load;
            end
        end
    end
endmodule
